// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP datapath.
// Provides the field layout, the exponent bias, a packed operand struct and the
// state type of the float-to-integer converter FSM.
package fp_pkg;

   localparam int unsigned FP_BIAS = 127;
   localparam int unsigned EXP_W   = 8;
   localparam int unsigned FRAC_W  = 23;

   // Bit positions of the fields inside a 32-bit word.
   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_MSB  = 30;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned FRAC_MSB = 22;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {
      IDLE,
      CLASS,
      SHIFT,
      DONE
   } f2i_state_t;

endpackage

// File: rtl/fp_to_int_converter_if.sv
// Request/response bundle of the float-to-integer converter.
//   start, a                        : request from the producer (master)
//   busy, done, result, overflow,
//   invalid                         : status and result from the converter (slave)
interface fp_to_int_converter_if #(
   parameter int unsigned INT_W = 32
);

   logic             start;
   logic [31:0]      a;
   logic             busy;
   logic             done;
   logic [INT_W-1:0] result;
   logic             overflow;
   logic             invalid;

   modport master (
      output start,
      output a,
      input  busy,
      input  done,
      input  result,
      input  overflow,
      input  invalid
   );

   modport slave (
      input  start,
      input  a,
      output busy,
      output done,
      output result,
      output overflow,
      output invalid
   );

endinterface

// File: rtl/fp_classify.sv
// Combinational field decode of an IEEE-754 single-precision word.
// Shared by the converter and the adder path.
//   a_i        : operand {sign, exp[7:0], frac[22:0]}
//   sign_o     : sign bit
//   is_zero_o  : exponent field is 0 (zero or denormal)
//   is_inf_o   : exponent all ones, fraction zero
//   is_nan_o   : exponent all ones, fraction non-zero
//   exp_unb_o  : unbiased exponent exp-127 (signed)
//   mant_o     : significand with hidden bit, {exp!=0, frac}
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0]       a_i,
   output logic              sign_o,
   output logic              is_zero_o,
   output logic              is_inf_o,
   output logic              is_nan_o,
   output logic signed [9:0] exp_unb_o,
   output logic [23:0]       mant_o
);

   logic [EXP_W-1:0]  exp_fld;
   logic [FRAC_W-1:0] frac_fld;
   logic              frac_zero;

   always_comb begin
      exp_fld   = a_i[EXP_MSB:EXP_LSB];
      frac_fld  = a_i[FRAC_MSB:0];
      frac_zero = (frac_fld == '0);
      sign_o    = a_i[SIGN_BIT];
      is_zero_o = (exp_fld == '0);
      is_inf_o  = (&exp_fld) && frac_zero;
      is_nan_o  = (&exp_fld) && !frac_zero;
      exp_unb_o = $signed(10'(exp_fld) - 10'(FP_BIAS));
      // Hidden bit is only present for normal numbers.
      mant_o    = {!is_zero_o, frac_fld};
   end

endmodule

// File: rtl/fp_to_int_converter.sv
// Multi-cycle IEEE-754 single precision to signed integer converter.
// Truncates toward zero, saturates out-of-range values, flags Inf/NaN as invalid.
// The significand is aligned one bit per cycle in a 32-bit shift register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fp_to_int_converter_if
//                start/a in; busy, done, result, overflow, invalid out
module fp_to_int_converter
   import fp_pkg::*;
#(
   parameter int unsigned INT_W = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   fp_to_int_converter_if.slave bus
);

   localparam logic [INT_W-1:0] IntMax = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] IntMin = {1'b1, {(INT_W-1){1'b0}}};
   localparam logic signed [9:0] EMax  = 10'(INT_W - 1);
   localparam logic signed [9:0] FracPt = 10'(FRAC_W);

   f2i_state_t       state_q;
   fp32_t            op_q;
   logic [4:0]       cnt_q;
   logic             dir_left_q;
   logic [31:0]      sh_q;
   logic             ovf_pend_q;
   logic             inv_pend_q;
   logic             sat_neg_q;
   logic             busy_q;
   logic             done_q;
   logic [INT_W-1:0] result_q;
   logic             overflow_q;
   logic             invalid_q;

   logic              cls_sign;
   logic              cls_zero;
   logic              cls_inf;
   logic              cls_nan;
   logic signed [9:0] cls_exp;
   logic [23:0]       cls_mant;
   logic              cls_ovf;

   fp_classify u_classify (
      .a_i       (op_q),
      .sign_o    (cls_sign),
      .is_zero_o (cls_zero),
      .is_inf_o  (cls_inf),
      .is_nan_o  (cls_nan),
      .exp_unb_o (cls_exp),
      .mant_o    (cls_mant)
   );

   // -2^(INT_W-1) is the one value with e == INT_W-1 that still fits.
   always_comb begin
      cls_ovf = (cls_exp > EMax) ||
                ((cls_exp == EMax) && !(cls_sign && (op_q.frac == '0)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         cnt_q      <= '0;
         dir_left_q <= 1'b0;
         sh_q       <= '0;
         ovf_pend_q <= 1'b0;
         inv_pend_q <= 1'b0;
         sat_neg_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  op_q    <= bus.a;
                  busy_q  <= 1'b1;
                  state_q <= CLASS;
               end
            end
            CLASS: begin
               sh_q       <= {8'd0, cls_mant};
               ovf_pend_q <= 1'b0;
               inv_pend_q <= 1'b0;
               sat_neg_q  <= cls_sign;
               cnt_q      <= '0;
               state_q    <= DONE;
               if (cls_inf || cls_nan) begin
                  inv_pend_q <= 1'b1;
                  // NaN saturates positive regardless of its sign bit.
                  sat_neg_q  <= cls_sign && cls_inf;
               end else if (cls_zero || (cls_exp < 10'sd0)) begin
                  sh_q <= '0;
               end else if (cls_ovf) begin
                  ovf_pend_q <= 1'b1;
               end else begin
                  cnt_q      <= 5'((cls_exp >= FracPt) ? (cls_exp - FracPt) : (FracPt - cls_exp));
                  dir_left_q <= (cls_exp >= FracPt);
                  if (cls_exp != FracPt) begin
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               // Right shifts drop fraction bits, which is truncation toward zero.
               sh_q  <= dir_left_q ? {sh_q[30:0], 1'b0} : {1'b0, sh_q[31:1]};
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (ovf_pend_q || inv_pend_q) begin
                  result_q <= sat_neg_q ? IntMin : IntMax;
               end else begin
                  result_q <= op_q.sign ? INT_W'(-sh_q) : INT_W'(sh_q);
               end
               overflow_q <= ovf_pend_q;
               invalid_q  <= inv_pend_q;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.overflow = overflow_q;
   assign bus.invalid  = invalid_q;

endmodule
